// File: rtl/vector_to_scalar_reducer_pkg.sv
// Shared types and identity helpers for the vector-to-scalar reducer.
// Optional MIN/MAX support is controlled by the V2S_MINMAX_EN macro.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package vector_to_scalar_reducer_pkg;

    typedef enum logic [2:0] {
        V2S_SUM    = 3'd0,
        V2S_AND    = 3'd1,
        V2S_OR     = 3'd2,
        V2S_BALLOT = 3'd3,
        V2S_MIN    = 3'd4,
        V2S_MAX    = 3'd5
    } v2s_op_t;

    typedef enum logic [1:0] {
        V2S_IDLE   = 2'd0,
        V2S_REDUCE = 2'd1,
        V2S_DONE   = 2'd2
    } v2s_state_t;

    // Identities are built 64 bits wide and truncated by the user to its data width.
    localparam logic [63:0] V2S_ID_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] V2S_ID_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic v2s_op_supported(input logic [2:0] op);
        logic ok;
        case (op)
            V2S_SUM, V2S_AND, V2S_OR, V2S_BALLOT: ok = 1'b1;
`ifdef V2S_MINMAX_EN
            V2S_MIN, V2S_MAX:                     ok = 1'b1;
`endif
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [63:0] v2s_identity(input logic [2:0] op, input int dw);
        logic [63:0] id;
        case (op)
            V2S_AND: id = V2S_ID_ONES;
`ifdef V2S_MINMAX_EN
            V2S_MIN: id = (64'd1 << (dw - 1)) - 64'd1;
            V2S_MAX: id = 64'd1 << (dw - 1);
`endif
            default: id = V2S_ID_ZERO;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/v2s_lane_combine.sv
// Folds one group of lanes into the running accumulator for the selected operator.
// MIN/MAX comparators exist only when V2S_MINMAX_EN is defined.
module v2s_lane_combine
    import vector_to_scalar_reducer_pkg::*;
#(
    parameter int DATA_WIDTH      = `DATA_WIDTH,
    parameter int LANES_PER_CYCLE = 4,
    parameter int IDX_W           = 4
) (
    input  logic [DATA_WIDTH-1:0]                 acc_i,
    input  logic [LANES_PER_CYCLE*DATA_WIDTH-1:0] lanes_i,
    input  logic [LANES_PER_CYCLE-1:0]            mask_i,
    input  logic [IDX_W-1:0]                      base_i,
    input  logic [2:0]                            op_i,
    output logic [DATA_WIDTH-1:0]                 acc_o
);

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] lane_s [LANES_PER_CYCLE];
    logic [DATA_WIDTH-1:0] acc_s;

    for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_unpack
        assign lane_s[g] = lanes_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Lane-serial fold; inactive lanes leave the accumulator untouched (identity).
    always_comb begin
        acc_s = acc_i;
        for (int j = 0; j < LANES_PER_CYCLE; j++) begin
            if (mask_i[j]) begin
                case (op_i)
                    V2S_SUM: acc_s = acc_s + lane_s[j];
                    V2S_AND: acc_s = acc_s & lane_s[j];
                    V2S_OR:  acc_s = acc_s | lane_s[j];
                    V2S_BALLOT: begin
                        if (lane_s[j] != {DATA_WIDTH{1'b0}}) begin
                            acc_s = acc_s | (ONE << (base_i + j));
                        end else begin
                            acc_s = acc_s;
                        end
                    end
`ifdef V2S_MINMAX_EN
                    V2S_MIN: begin
                        if ($signed(lane_s[j]) < $signed(acc_s)) begin
                            acc_s = lane_s[j];
                        end else begin
                            acc_s = acc_s;
                        end
                    end
                    V2S_MAX: begin
                        if ($signed(lane_s[j]) > $signed(acc_s)) begin
                            acc_s = lane_s[j];
                        end else begin
                            acc_s = acc_s;
                        end
                    end
`endif
                    default: acc_s = {DATA_WIDTH{1'b0}};
                endcase
            end else begin
                acc_s = acc_s;
            end
        end
        acc_o = acc_s;
    end

endmodule

// File: rtl/vector_to_scalar_reducer.sv
// Multi-cycle warp vector to scalar reduction (SUM/AND/OR/BALLOT, MIN/MAX with V2S_MINMAX_EN).
// Walks LANES_PER_CYCLE lanes per enabled cycle and holds the result with a done strobe.
module vector_to_scalar_reducer
    import vector_to_scalar_reducer_pkg::*;
#(
    parameter int DATA_WIDTH       = `DATA_WIDTH,
    parameter int THREADS_PER_WARP = 16,
    parameter int LANES_PER_CYCLE  = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   start,
    input  logic [2:0]                             op,
    input  logic [THREADS_PER_WARP*DATA_WIDTH-1:0] vector_data,
    input  logic [DATA_WIDTH-1:0]                  execution_mask,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   op_error,
    output logic [DATA_WIDTH-1:0]                  vector_to_scalar_data
);

    localparam int IDX_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(THREADS_PER_WARP - LANES_PER_CYCLE);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES_PER_CYCLE);

    v2s_state_t                             state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [DATA_WIDTH-1:0]                  acc_q, acc_d;
    logic [THREADS_PER_WARP*DATA_WIDTH-1:0] data_q, data_d;
    logic [THREADS_PER_WARP-1:0]            mask_q, mask_d;
    logic [2:0]                             op_q, op_d;
    logic [DATA_WIDTH-1:0]                  result_q, result_d;
    logic                                   busy_q, busy_d;
    logic                                   done_q, done_d;
    logic                                   op_error_q, op_error_d;

    logic [DATA_WIDTH-1:0]                  ident_s;
    logic [LANES_PER_CYCLE*DATA_WIDTH-1:0]  group_s;
    logic [LANES_PER_CYCLE-1:0]             group_mask_s;
    logic [DATA_WIDTH-1:0]                  next_acc_s;

    if (DATA_WIDTH > THREADS_PER_WARP) begin : g_mask_upper
        logic unused_mask_s;
        assign unused_mask_s = ^execution_mask[DATA_WIDTH-1:THREADS_PER_WARP];
    end

    assign ident_s      = DATA_WIDTH'(v2s_identity(op, DATA_WIDTH));
    assign group_s      = data_q[idx_q*DATA_WIDTH +: LANES_PER_CYCLE*DATA_WIDTH];
    assign group_mask_s = mask_q[idx_q +: LANES_PER_CYCLE];

    v2s_lane_combine #(
        .DATA_WIDTH      (DATA_WIDTH),
        .LANES_PER_CYCLE (LANES_PER_CYCLE),
        .IDX_W           (IDX_W)
    ) u_combine (
        .acc_i   (acc_q),
        .lanes_i (group_s),
        .mask_i  (group_mask_s),
        .base_i  (idx_q),
        .op_i    (op_q),
        .acc_o   (next_acc_s)
    );

    // Next-state logic; everything holds while enable is low.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        data_d     = data_q;
        mask_d     = mask_q;
        op_d       = op_q;
        result_d   = result_q;
        op_error_d = op_error_q;
        if (enable) begin
            case (state_q)
                V2S_IDLE: begin
                    if (start) begin
                        state_d = V2S_REDUCE;
                        data_d  = vector_data;
                        mask_d  = execution_mask[THREADS_PER_WARP-1:0];
                        op_d    = op;
                        acc_d   = ident_s;
                        idx_d   = {IDX_W{1'b0}};
                    end else begin
                        state_d = V2S_IDLE;
                    end
                end
                V2S_REDUCE: begin
                    acc_d = next_acc_s;
                    if (idx_q == LAST_IDX) begin
                        idx_d      = {IDX_W{1'b0}};
                        result_d   = next_acc_s;
                        op_error_d = ~v2s_op_supported(op_q);
                        state_d    = V2S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_STEP;
                    end
                end
                V2S_DONE: begin
                    op_error_d = 1'b0;
                    state_d    = V2S_IDLE;
                end
                default: begin
                    op_error_d = 1'b0;
                    state_d    = V2S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != V2S_IDLE);
        done_d = (state_d == V2S_DONE);
    end

    // State and output registers; reset discards any in-flight reduction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= V2S_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            acc_q      <= {DATA_WIDTH{1'b0}};
            data_q     <= {(THREADS_PER_WARP*DATA_WIDTH){1'b0}};
            mask_q     <= {THREADS_PER_WARP{1'b0}};
            op_q       <= 3'd0;
            result_q   <= {DATA_WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            op_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            op_q       <= op_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            op_error_q <= op_error_d;
        end
    end

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign op_error              = op_error_q;
    assign vector_to_scalar_data = result_q;

endmodule

// File: tb/tb_vector_to_scalar_reducer.sv
// Directed self-checking bench for vector_to_scalar_reducer (default parameters).
module tb_vector_to_scalar_reducer;

    localparam int DW  = 32;
    localparam int TPW = 16;
    localparam int LPC = 4;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              enable;
    logic              start;
    logic [2:0]        op;
    logic [TPW*DW-1:0] vector_data;
    logic [DW-1:0]     execution_mask;
    logic              busy;
    logic              done;
    logic              op_error;
    logic [DW-1:0]     vector_to_scalar_data;

    int tests = 0;
    int fails = 0;
    int lat;

    always #5 clk = ~clk;

    vector_to_scalar_reducer #(
        .DATA_WIDTH       (DW),
        .THREADS_PER_WARP (TPW),
        .LANES_PER_CYCLE  (LPC)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .enable                (enable),
        .start                 (start),
        .op                    (op),
        .vector_data           (vector_data),
        .execution_mask        (execution_mask),
        .busy                  (busy),
        .done                  (done),
        .op_error              (op_error),
        .vector_to_scalar_data (vector_to_scalar_data)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then wait (bounded) for done; lat = edges after acceptance.
    task automatic run(input logic [2:0] o, input logic [DW-1:0] m, output int l);
        op             = o;
        execution_mask = m;
        start          = 1'b1;
        step();
        start = 1'b0;
        l     = 0;
        while (done !== 1'b1 && l < 20) begin
            step();
            l++;
        end
    endtask

    initial begin
        enable         = 1'b1;
        start          = 1'b0;
        op             = 3'd0;
        vector_data    = '0;
        execution_mask = '0;

        // Reset state
        #2 reset = 1'b0;
        #2;
        chk("rst_busy", DW'(busy), 32'd0);
        chk("rst_done", DW'(done), 32'd0);
        chk("rst_err", DW'(op_error), 32'd0);
        chk("rst_data", vector_to_scalar_data, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // SUM of 1..16, full mask
        for (int i = 0; i < TPW; i++) vector_data[i*DW +: DW] = DW'(i + 1);
        run(3'd0, 32'h0000_FFFF, lat);
        chk("sum_lat", DW'(lat), 32'd4);
        chk("sum_res", vector_to_scalar_data, 32'd136);
        chk("sum_err", DW'(op_error), 32'd0);
        step();
        chk("sum_idle_busy", DW'(busy), 32'd0);
        chk("sum_hold", vector_to_scalar_data, 32'd136);

        // SUM wraparound and empty mask
        for (int i = 0; i < TPW; i++) vector_data[i*DW +: DW] = 32'hFFFF_FFFF;
        run(3'd0, 32'h0000_0003, lat);
        chk("sum_wrap", vector_to_scalar_data, 32'hFFFF_FFFE);
        step();
        run(3'd0, 32'h0000_0000, lat);
        chk("sum_mask0", vector_to_scalar_data, 32'd0);
        step();

        // BALLOT: odd lanes hold 5; upper mask bits beyond the warp are ignored
        for (int i = 0; i < TPW; i++) vector_data[i*DW +: DW] = (i % 2 == 1) ? 32'd5 : 32'd0;
        run(3'd3, 32'hFFFF_00FF, lat);
        chk("ballot", vector_to_scalar_data, 32'h0000_00AA);
        step();

        // OR of one-hot lanes under a partial mask
        for (int i = 0; i < TPW; i++) vector_data[i*DW +: DW] = 32'd1 << i;
        run(3'd2, 32'h0000_00F0, lat);
        chk("or_res", vector_to_scalar_data, 32'h0000_00F0);
        step();

        // MIN over {-3, 7, 2..14, 2}
        vector_data[0*DW +: DW] = 32'hFFFF_FFFD;
        vector_data[1*DW +: DW] = 32'd7;
        for (int i = 2; i < TPW - 1; i++) vector_data[i*DW +: DW] = DW'(i);
        vector_data[15*DW +: DW] = 32'd2;
        run(3'd4, 32'h0000_FFFF, lat);
`ifdef V2S_MINMAX_EN
        chk("min_res", vector_to_scalar_data, 32'hFFFF_FFFD);
        chk("min_err", DW'(op_error), 32'd0);
`else
        chk("min_res", vector_to_scalar_data, 32'd0);
        chk("min_err", DW'(op_error), 32'd1);
`endif
        step();

        // Unsupported code 7 still runs the full sequence
        run(3'd7, 32'h0000_FFFF, lat);
        chk("bad_lat", DW'(lat), 32'd4);
        chk("bad_res", vector_to_scalar_data, 32'd0);
        chk("bad_err", DW'(op_error), 32'd1);
        step();
        chk("bad_err_clr", DW'(op_error), 32'd0);

        // Enable low 3 cycles mid-REDUCE, with a start pulse and new inputs while busy
        for (int i = 0; i < TPW; i++) vector_data[i*DW +: DW] = DW'(i + 1);
        op             = 3'd0;
        execution_mask = 32'h0000_FFFF;
        start          = 1'b1;
        step();
        start = 1'b0;
        step();
        lat         = 2;
        enable      = 1'b0;
        start       = 1'b1;
        op          = 3'd1;
        vector_data = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            lat++;
        end
        chk("frz_done", DW'(done), 32'd0);
        chk("frz_busy", DW'(busy), 32'd1);
        enable = 1'b1;
        while (done !== 1'b1 && lat < 30) begin
            step();
            lat++;
        end
        start = 1'b0;
        chk("frz_lat", DW'(lat), 32'd8);
        chk("frz_res", vector_to_scalar_data, 32'd136);
        enable = 1'b0;
        step();
        step();
        chk("frz_done_hold", DW'(done), 32'd1);
        enable = 1'b1;
        step();
        chk("frz_done_clr", DW'(done), 32'd0);
        chk("frz_busy_clr", DW'(busy), 32'd0);

        // Asynchronous reset mid-REDUCE, then AND with empty and partial masks
        for (int i = 0; i < TPW; i++) vector_data[i*DW +: DW] = 32'hFFFF_FFFF;
        vector_data[9*DW +: DW] = 32'h1234_5678;
        op             = 3'd0;
        execution_mask = 32'h0000_FFFF;
        start          = 1'b1;
        step();
        start = 1'b0;
        step();
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", DW'(busy), 32'd0);
        chk("arst_done", DW'(done), 32'd0);
        chk("arst_err", DW'(op_error), 32'd0);
        chk("arst_data", vector_to_scalar_data, 32'd0);
        step();
        reset = 1'b1;
        step();
        run(3'd1, 32'h0000_0000, lat);
        chk("and_mask0", vector_to_scalar_data, 32'hFFFF_FFFF);
        step();
        run(3'd1, 32'h0000_FFFF, lat);
        chk("and_full", vector_to_scalar_data, 32'h1234_5678);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
